// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-channel arbiter.
// Imported by arb_pick and fsm_arbiter_n.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Hold counter width; the timeout-disabled case still needs one bit.
  function automatic int cnt_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the arbiter.
// Fixed priority and round-robin share one masked priority encoder.
module arb_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       mode,
  input  logic [$clog2(NUM_REQ)-1:0] last_id,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic                 found;
  int                   start;

  // Search {req,req} from start upward; the upper copy provides the wrap.
  always_comb begin
    dbl    = {req, req};
    start  = 0;
    found  = 1'b0;
    winner = '0;
    any    = |req;
    if (mode == ARB_RR) begin
      if (int'(last_id) >= NUM_REQ - 1) start = 0;
      else start = int'(last_id) + 1;
    end
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (!found && dbl[i] && (i >= start)) begin
        found  = 1'b1;
        winner = IDW'(i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fsm_arbiter_n.sv
// N-channel request/grant arbiter with fixed or round-robin
// selection and an optional maximum-hold forced release.
module fsm_arbiter_n
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       mode,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = cnt_width(MAX_HOLD);
  localparam logic          HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               vld_q, vld_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               to_q, to_d;

  logic [IDW-1:0]     pick_id;
  logic               pick_any;

  arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .mode    (mode),
    .last_id (last_q),
    .winner  (pick_id),
    .any     (pick_any)
  );

  // State and output registers; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Arbitrate in IDLE; in GRANT hold until release or hold limit.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = ONE << pick_id;
          vld_d   = 1'b1;
          id_d    = pick_id;
          last_d  = pick_id;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
        end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          to_d    = 1'b1;
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign gnt_id    = id_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_fsm_arbiter_n.sv
// Scoreboard bench for fsm_arbiter_n over three configurations:
// (4,MAX_HOLD=3), (4,MAX_HOLD=0) and (5,MAX_HOLD=0).
module tb_fsm_arbiter_n;

  typedef struct {
    int         dut;
    logic [4:0] gnt;
    logic [4:0] id;
    logic       to;
    string      nm;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rs [3];
  logic [4:0] rq [3];
  logic       md [3];

  logic [3:0] g0, g1;
  logic [4:0] g2;
  logic       v0, v1, v2;
  logic [1:0] i0, i1;
  logic [2:0] i2;
  logic       t0, t1, t2;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fsm_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(3)) dut_a (
    .clock(clock), .reset(rs[0]), .req(rq[0][3:0]), .mode(md[0]),
    .gnt(g0), .gnt_valid(v0), .gnt_id(i0), .timeout(t0)
  );

  fsm_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(0)) dut_b (
    .clock(clock), .reset(rs[1]), .req(rq[1][3:0]), .mode(md[1]),
    .gnt(g1), .gnt_valid(v1), .gnt_id(i1), .timeout(t1)
  );

  fsm_arbiter_n #(.NUM_REQ(5), .MAX_HOLD(0)) dut_c (
    .clock(clock), .reset(rs[2]), .req(rq[2]), .mode(md[2]),
    .gnt(g2), .gnt_valid(v2), .gnt_id(i2), .timeout(t2)
  );

  task automatic chk(input string nm, input string f,
                     input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h want %0h @%0t", nm, f, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle, away from the edge.
  initial begin
    exp_t       e;
    logic [4:0] ag, ai;
    logic       av, at;
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.dut)
          0: begin ag = {1'b0, g0}; av = v0; ai = {3'b0, i0}; at = t0; end
          1: begin ag = {1'b0, g1}; av = v1; ai = {3'b0, i1}; at = t1; end
          default: begin ag = g2; av = v2; ai = {2'b0, i2}; at = t2; end
        endcase
        chk(e.nm, "gnt", {3'b0, ag}, {3'b0, e.gnt});
        chk(e.nm, "gnt_valid", {7'b0, av}, {7'b0, |e.gnt});
        chk(e.nm, "gnt_id", {3'b0, ai}, {3'b0, e.id});
        chk(e.nm, "timeout", {7'b0, at}, {7'b0, e.to});
      end
    end
  end

  // Drive one cycle of inputs; expect these outputs after the edge.
  task automatic step(input int d, input logic r, input logic [4:0] q,
                      input logic m, input logic [4:0] eg,
                      input logic [4:0] eid, input logic eto,
                      input string nm);
    exp_t e;
    rs[d] = r;
    rq[d] = q;
    md[d] = m;
    @(posedge clock);
    #1;
    e.dut = d;
    e.gnt = eg;
    e.id  = eid;
    e.to  = eto;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b1;
      rq[i] = '0;
      md[i] = 1'b0;
    end
    @(posedge clock);
    #1;

    // Reset with all requests, first grant in both modes.
    step(1, 1, 5'hF, 0, 5'h0, 0, 0, "rst_hold");
    step(1, 1, 5'hF, 0, 5'h0, 0, 0, "rst_hold");
    step(1, 0, 5'hF, 0, 5'h1, 0, 0, "first_fix");
    step(1, 1, 5'hF, 1, 5'h0, 0, 0, "rst_in_grant");
    step(1, 0, 5'hF, 1, 5'h1, 0, 0, "first_rr");

    // Fixed priority and handover with one idle gap.
    step(1, 1, 5'h0, 0, 5'h0, 0, 0, "rst");
    step(1, 0, 5'hA, 0, 5'h2, 1, 0, "fix_1010");
    step(1, 0, 5'hA, 0, 5'h2, 1, 0, "fix_hold");
    step(1, 0, 5'h8, 0, 5'h0, 1, 0, "fix_rel");
    step(1, 0, 5'h8, 0, 5'h8, 3, 0, "fix_next");
    step(1, 0, 5'h0, 0, 5'h0, 3, 0, "fix_idle");

    // No timeout: hold channel 2 for 100 cycles.
    step(1, 1, 5'h0, 0, 5'h0, 0, 0, "rst");
    for (int c = 0; c < 100; c++)
      step(1, 0, 5'h4, 0, 5'h4, 2, 0, "hold0");
    step(1, 0, 5'h0, 0, 5'h0, 2, 0, "hold0_rel");

    // Mid-grant reset restores last_id.
    step(1, 1, 5'h0, 1, 5'h0, 0, 0, "rst");
    step(1, 0, 5'h8, 1, 5'h8, 3, 0, "rr_3");
    step(1, 0, 5'h8, 1, 5'h8, 3, 0, "rr_3_hold");
    step(1, 1, 5'h8, 1, 5'h0, 0, 0, "mid_rst");
    step(1, 0, 5'hF, 1, 5'h1, 0, 0, "rr_after_rst");
    step(1, 1, 5'h0, 1, 5'h0, 0, 0, "rst");
    step(1, 0, 5'h2, 1, 5'h2, 1, 0, "rr_1");
    step(1, 1, 5'hF, 1, 5'h0, 0, 0, "mid_rst2");
    step(1, 0, 5'hF, 1, 5'h1, 0, 0, "rr_restart");
    rs[1] = 1'b1;

    // Round-robin rotation with MAX_HOLD = 3.
    step(0, 1, 5'h0, 1, 5'h0, 0, 0, "rst_a");
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++)
        step(0, 0, 5'hF, 1, 5'(1 << (k % 4)), 5'(k % 4), 0, "rr_ten");
      if (k < 4)
        step(0, 0, 5'hF, 1, 5'h0, 5'(k), 1, "rr_to");
    end

    // Fixed mode: timed-out channel re-wins.
    step(0, 1, 5'h0, 0, 5'h0, 0, 0, "rst_a");
    for (int c = 0; c < 3; c++)
      step(0, 0, 5'h1, 0, 5'h1, 0, 0, "fx_ten");
    step(0, 0, 5'h1, 0, 5'h0, 0, 1, "fx_to");
    step(0, 0, 5'h1, 0, 5'h1, 0, 0, "fx_rewin");
    rs[0] = 1'b1;

    // Five channels, round-robin wrap-around.
    step(2, 1, 5'h00, 1, 5'h00, 0, 0, "rst_c");
    step(2, 0, 5'h10, 1, 5'h10, 4, 0, "c_4");
    step(2, 0, 5'h00, 1, 5'h00, 4, 0, "c_rel");
    step(2, 0, 5'h11, 1, 5'h01, 0, 0, "c_wrap");
    step(2, 0, 5'h00, 1, 5'h00, 0, 0, "c_rel");
    step(2, 0, 5'h11, 1, 5'h10, 4, 0, "c_next");
    step(2, 0, 5'h00, 1, 5'h00, 4, 0, "c_rel");
    step(2, 0, 5'h08, 1, 5'h08, 3, 0, "c_3");
    step(2, 0, 5'h00, 1, 5'h00, 3, 0, "c_rel");
    step(2, 0, 5'h05, 1, 5'h01, 0, 0, "c_wrap2");
    step(2, 0, 5'h00, 1, 5'h00, 0, 0, "c_rel");
    step(2, 0, 5'h06, 0, 5'h02, 1, 0, "c_fix");

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_arbiter_n.md
# fsm_arbiter_n

Parametrised N-channel request/grant arbiter that supersedes the fixed 4-channel priority grant FSM. Grants exactly one requester at a time and holds the grant while that requester keeps its request asserted. Adds runtime-selectable fixed-priority or round-robin arbitration and an optional maximum-hold timeout that forces release. Sits between N bus or resource clients and a shared resource; outputs are registered and directly drive resource select muxes.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..32
- MAX_HOLD, 0, maximum consecutive grant cycles per tenure; 0 disables the timeout; legal range 0..65535
- IDW, $clog2(NUM_REQ), width of the grant index; derived, not overridden
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clock clock
- req  in  NUM_REQ  request vector; bit i = requester i
- mode  in  1  0 = fixed priority (bit 0 highest), 1 = round-robin; sampled only in IDLE
- gnt  out  NUM_REQ  registered one-hot grant, or all-zero
- gnt_valid  out  1  OR of gnt
- gnt_id  out  IDW  index of the granted requester; holds its last value when gnt_valid = 0
- timeout  out  1  one-cycle pulse in the cycle where a grant is force-released

## Operation
- Two states: IDLE and GRANT. The grant index register is separate from the state.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick a winner and go to GRANT with gnt = onehot(winner) and gnt_id = winner.
- Winner selection, fixed priority (mode = 0): lowest set index of req.
- Winner selection, round-robin (mode = 1):
  - Pick the first set bit searching upward from last_id+1, wrapping modulo NUM_REQ.
  - last_id is updated to the winner on every grant, in both modes.
- GRANT:
  - If req[gnt_id] == 0, go to IDLE and clear gnt.
  - Else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1, go to IDLE, clear gnt and pulse timeout.
  - Otherwise stay in GRANT.
  - Requests from other channels are ignored while in GRANT.
- Every grant tenure is followed by at least one IDLE cycle with gnt = 0, giving break-before-make.
- hold_cnt:
  - Width $clog2(MAX_HOLD+1); minimum 1 bit.
  - Cleared on entry to GRANT; increments each GRANT cycle.
  - Saturates and never wraps.
- After a timeout the released channel may re-win:
  - Fixed mode: it re-wins if it is still the highest-priority requester.
  - Round-robin mode: it is ranked last.
- Reset values: state = IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0, timeout = 0, last_id = NUM_REQ-1 (so channel 0 is searched first), hold_cnt = 0.
- Reset is synchronous and dominates every other event. Asserting it mid-grant clears gnt at the next edge.

## Timing
- Request-to-grant latency:
  - req sampled in IDLE at edge t drives gnt high after edge t.
  - One cycle from req rising to gnt rising when the arbiter is idle.
- Release: the holder dropping req before edge t drives gnt low after edge t.
- A tenure with timeout lasts exactly MAX_HOLD cycles of gnt high. timeout is high in the first IDLE cycle after the tenure, coincident with gnt = 0.
- Handover:
  - When the holder releases while another channel requests, the sequence is gnt = A, then one cycle of 0, then gnt = B.
  - Minimum handover gap is 1 cycle.
- mode changes during GRANT take effect at the next IDLE arbitration.
- All outputs are flops. There is no combinational path from req or mode to any output.

## Structure
- Shared package arb_pkg contains:
  - state enum {IDLE, GRANT}
  - mode constants ARB_FIXED = 1'b0 and ARB_RR = 1'b1
  - a helper function computing the counter width from MAX_HOLD
- Sub-module arb_pick:
  - Purely combinational; parameter NUM_REQ.
  - Inputs: req, mode, last_id.
  - Outputs: winner index and any.
  - Implements round-robin as a double-width masked priority encode.
- fsm_arbiter_n holds the FSM, gnt/gnt_id/last_id registers, hold_cnt and timeout.

## Test plan
- Reset with req = 4'b1111 held → gnt = 0, gnt_id = 0, timeout = 0. First grant after reset release is 4'b0001 one cycle later in both modes.
- Fixed priority, NUM_REQ = 4, req = 4'b1010 → gnt = 4'b0010. Drop req[1] → one idle cycle, then gnt = 4'b1000.
- Round-robin, req = 4'b1111 constant, MAX_HOLD = 3 → grants rotate 0, 1, 2, 3, 0:
  - each tenure is 3 cycles high followed by 1 idle cycle
  - timeout pulses once per tenure
- MAX_HOLD = 0, req[2] held for 100 cycles → gnt = 4'b0100 for all 100 cycles and timeout is never asserted.
- Mid-grant reset: assert reset during a GRANT of channel 3 → gnt = 0 at the next edge. After release, round-robin grants channel 0 first (last_id restored to 3).
- NUM_REQ = 5, round-robin, last_id = 4, req = 5'b10001 → winner is 0 (wrap-around), then 4 on the next arbitration.
